// File: rtl/vdp_pkg.sv
// Shared video-path definitions: frame geometry, pixel/address types and
// the write-scheduler state encoding.
package vdp_pkg;

  localparam int unsigned DW    = 24;
  localparam int unsigned AW    = 16;
  localparam int unsigned SCR_W = 280;
  localparam int unsigned SCR_H = 192;
  localparam int unsigned NPIX  = SCR_W * SCR_H;

  typedef logic [DW-1:0] pixel_t;
  typedef logic [AW-1:0] vadr_t;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } sched_state_t;

endpackage

// File: rtl/vram_wr_sched_rr_arb2.sv
// Two-input round-robin arbiter with a registered favour pointer.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_en       : arbitration allowed this cycle
//   i_req[1:0] : request vector (bit n = requester n)
//   o_gnt_c    : one-hot (or zero) combinational grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt_c
);

  logic r_rr;

  // Pointer picks the winner only under contention; a lone request always wins.
  always_comb begin
    o_gnt_c = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) begin
        o_gnt_c[r_rr] = 1'b1;
      end else begin
        o_gnt_c = i_req;
      end
    end
  end

  // Any grant hands the favour to the opposite side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= 1'b0;
    end else if (o_gnt_c[0]) begin
      r_rr <= 1'b1;
    end else if (o_gnt_c[1]) begin
      r_rr <= 1'b0;
    end
  end

endmodule

// File: rtl/vram_wr_sched.sv
// VRAM write-port scheduler: round-robin between two pixel producers, plus a
// whole-frame fill sequencer that takes over the port while running.
// Ports:
//   clk, res               : clock, async active-low reset
//   r0_*/r1_*              : valid/ready pixel requesters (adr, d)
//   clr_start, clr_color   : fill request pulse and colour
//   clr_busy               : fill in progress
//   oor                    : pulse, accepted pixel dropped (adr >= NPIX)
//   vram_we/wadr/d         : registered write port to VRAM
module vram_wr_sched
  import vdp_pkg::*;
#(
  parameter int unsigned DW   = vdp_pkg::DW,
  parameter int unsigned AW   = vdp_pkg::AW,
  parameter int unsigned NPIX = vdp_pkg::NPIX
) (
  input  logic          clk,
  input  logic          res,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [AW-1:0] r0_adr,
  input  logic [DW-1:0] r0_d,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [AW-1:0] r1_adr,
  input  logic [DW-1:0] r1_d,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output logic          oor,
  output logic          vram_we,
  output logic [AW-1:0] vram_wadr,
  output logic [DW-1:0] vram_d
);

  // Counter must be able to reach every frame address.
  if (64'(NPIX) > (64'd1 << AW)) begin : g_npix_chk
    $error("vram_wr_sched: NPIX does not fit in AW address bits");
  end

  localparam logic [AW-1:0] LAST_ADR = AW'(NPIX - 1);

  sched_state_t  r_state, w_state_nxt;
  logic          r_we, w_we_nxt;
  logic [AW-1:0] r_wadr, w_wadr_nxt;
  logic [DW-1:0] r_d, w_d_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic [DW-1:0] r_color, w_color_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_oor, w_oor_nxt;

  logic          w_arb_en;
  logic [1:0]    w_gnt;
  logic [AW-1:0] w_sel_adr;
  logic [DW-1:0] w_sel_d;
  logic          w_in_range;

  // A fill request pre-empts both requesters in the cycle it arrives.
  assign w_arb_en = (r_state == ARB) && !clr_start;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (res),
    .i_en    (w_arb_en),
    .i_req   ({r1_valid, r0_valid}),
    .o_gnt_c (w_gnt)
  );

  assign r0_ready   = w_gnt[0];
  assign r1_ready   = w_gnt[1];
  assign w_sel_adr  = w_gnt[1] ? r1_adr : r0_adr;
  assign w_sel_d    = w_gnt[1] ? r1_d : r0_d;
  assign w_in_range = 64'(w_sel_adr) < 64'(NPIX);

  // Next-state and next-output logic; address/data hold unless written.
  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = 1'b0;
    w_wadr_nxt  = r_wadr;
    w_d_nxt     = r_d;
    w_cnt_nxt   = r_cnt;
    w_color_nxt = r_color;
    w_busy_nxt  = r_busy;
    w_oor_nxt   = 1'b0;
    case (r_state)
      ARB: begin
        if (clr_start) begin
          // First fill write (address 0) is issued together with busy rising.
          w_state_nxt = CLEAR;
          w_color_nxt = clr_color;
          w_cnt_nxt   = '0;
          w_we_nxt    = 1'b1;
          w_wadr_nxt  = '0;
          w_d_nxt     = clr_color;
          w_busy_nxt  = 1'b1;
        end else if (|w_gnt) begin
          if (w_in_range) begin
            w_we_nxt   = 1'b1;
            w_wadr_nxt = w_sel_adr;
            w_d_nxt    = w_sel_d;
          end else begin
            w_oor_nxt  = 1'b1;
          end
        end
      end
      CLEAR: begin
        // r_cnt is the address currently on the write port.
        if (r_cnt == LAST_ADR) begin
          w_state_nxt = ARB;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt  = r_cnt + AW'(1);
          w_we_nxt   = 1'b1;
          w_wadr_nxt = r_cnt + AW'(1);
          w_d_nxt    = r_color;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= ARB;
      r_we    <= 1'b0;
      r_wadr  <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_color <= '0;
      r_busy  <= 1'b0;
      r_oor   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_we_nxt;
      r_wadr  <= w_wadr_nxt;
      r_d     <= w_d_nxt;
      r_cnt   <= w_cnt_nxt;
      r_color <= w_color_nxt;
      r_busy  <= w_busy_nxt;
      r_oor   <= w_oor_nxt;
    end
  end

  assign vram_we   = r_we;
  assign vram_wadr = r_wadr;
  assign vram_d    = r_d;
  assign clr_busy  = r_busy;
  assign oor       = r_oor;

endmodule

// File: tb/tb_vram_wr_sched.sv
// Scoreboard bench for vram_wr_sched: a frame-level reference model predicts
// readies/busy each cycle and queues the write (or drop) each accepted pixel
// or fill must produce; a negedge monitor matches the write port against it.
module tb_vram_wr_sched;

  localparam int unsigned NP = 280 * 192;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        r0_valid = 1'b0, r1_valid = 1'b0;
  logic        r0_ready, r1_ready;
  logic [15:0] r0_adr = '0, r1_adr = '0;
  logic [23:0] r0_d = '0, r1_d = '0;
  logic        clr_start = 1'b0;
  logic [23:0] clr_color = '0;
  logic        clr_busy, oor, vram_we;
  logic [15:0] vram_wadr;
  logic [23:0] vram_d;

  vram_wr_sched dut (
    .clk       (clk),
    .res       (res),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_adr    (r0_adr),
    .r0_d      (r0_d),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_adr    (r1_adr),
    .r1_d      (r1_d),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .oor       (oor),
    .vram_we   (vram_we),
    .vram_wadr (vram_wadr),
    .vram_d    (vram_d)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit drop;
    int adr;
    int d;
    int due;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_fav = 0;       // requester favoured under contention
  int   m_left = 0;      // remaining fill cycles
  int   m_last_adr = 0;  // last address/data actually written
  int   m_last_d = 0;
  bit   m_acc0, m_acc1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_pix(input logic [15:0] adr, input logic [23:0] d);
    exp_t e;
    e.drop = (int'(adr) >= int'(NP));
    e.adr  = int'(adr);
    e.d    = int'(d);
    e.due  = cyc + 1;
    q.push_back(e);
  endtask

  // Reference model: evaluated once per cycle with inputs settled.
  task automatic check_model();
    bit e0, e1, start;
    exp_t e;
    e0 = 0; e1 = 0; start = 0;
    if (m_left == 0) begin
      if (clr_start) start = 1;
      else if (r0_valid && r1_valid) begin
        if (m_fav == 0) e0 = 1; else e1 = 1;
      end else if (r0_valid) e0 = 1;
      else if (r1_valid) e1 = 1;
    end
    chk("r0_ready", r0_ready, e0);
    chk("r1_ready", r1_ready, e1);
    chk("clr_busy", clr_busy, m_left > 0);
    m_acc0 = e0;
    m_acc1 = e1;
    if (e0) begin push_pix(r0_adr, r0_d); m_fav = 1; end
    if (e1) begin push_pix(r1_adr, r1_d); m_fav = 0; end
    if (m_left > 0) m_left--;
    if (start) begin
      m_left = NP;
      for (int i = 0; i < int'(NP); i++) begin
        e.drop = 0; e.adr = i; e.d = int'(clr_color); e.due = cyc + 1 + i;
        q.push_back(e);
      end
    end
  endtask

  // Monitor: every cycle the write port must match the queue head or be idle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!res) begin
      chk("rst_we", vram_we, 0);
      chk("rst_oor", oor, 0);
    end else if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (e.drop) begin
        chk("oor_pulse", oor, 1);
        chk("oor_we", vram_we, 0);
        chk("oor_hold_adr", vram_wadr, m_last_adr);
        chk("oor_hold_d", vram_d, m_last_d);
      end else begin
        chk("we", vram_we, 1);
        chk("oor_quiet", oor, 0);
        chk("wadr", vram_wadr, e.adr);
        chk("wdata", vram_d, e.d);
        m_last_adr = e.adr;
        m_last_d   = e.d;
      end
    end else begin
      chk("idle_we", vram_we, 0);
      chk("idle_oor", oor, 0);
      chk("hold_adr", vram_wadr, m_last_adr);
      chk("hold_d", vram_d, m_last_d);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_check();
    #3;
    check_model();
  endtask

  task automatic apply_reset(input int n);
    next_cycle();
    res = 1'b0;
    q.delete();
    m_fav = 0; m_left = 0; m_last_adr = 0; m_last_d = 0;
    #1;
    chk("rst_now_we", vram_we, 0);
    chk("rst_now_adr", vram_wadr, 0);
    chk("rst_now_d", vram_d, 0);
    chk("rst_now_busy", clr_busy, 0);
    chk("rst_now_oor", oor, 0);
    repeat (n - 1) next_cycle();
    next_cycle();
    res = 1'b1;
    settle_check();
  endtask

  function automatic logic [15:0] rand_adr();
    if ($urandom_range(0, 7) == 0) return 16'($urandom_range(NP, 65535));
    return 16'($urandom_range(0, NP - 1));
  endfunction

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int  k;
    bit  got;

    // Reset, then idle.
    apply_reset(3);
    repeat (10) begin next_cycle(); settle_check(); end

    // Single requester streaming 0..7.
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      r0_valid = 1; r0_adr = 16'(i); r0_d = 24'hffffff;
      settle_check();
    end
    next_cycle(); r0_valid = 0; settle_check();

    // Contention from reset: r0 first, then alternating.
    apply_reset(3);
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      r0_valid = 1; r0_adr = 16'h0010; r0_d = 24'h111111;
      r1_valid = 1; r1_adr = 16'h0020; r1_d = 24'h222222;
      settle_check();
    end
    next_cycle(); r0_valid = 0; r1_valid = 0; settle_check();

    // Out-of-range drop, then the last valid address.
    next_cycle(); r1_valid = 1; r1_adr = 16'(NP); r1_d = 24'h123456; settle_check();
    next_cycle(); r1_adr = 16'(NP - 1); r1_d = 24'h654321; settle_check();
    next_cycle(); r1_valid = 0; settle_check();

    // Random traffic with protocol-correct holds.
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      if (!r0_valid || m_acc0) begin
        r0_valid = 1'($urandom_range(0, 1)); r0_adr = rand_adr(); r0_d = 24'($urandom);
      end
      if (!r1_valid || m_acc1) begin
        r1_valid = 1'($urandom_range(0, 1)); r1_adr = rand_adr(); r1_d = 24'($urandom);
      end
      settle_check();
    end
    next_cycle(); r0_valid = 0; r1_valid = 0; settle_check();

    // Fill while r0 is waiting; a second start mid-fill must be ignored.
    next_cycle();
    r0_valid = 1; r0_adr = 16'd100; r0_d = 24'habcdef;
    clr_start = 1; clr_color = 24'h0000ff;
    settle_check();
    k = 0; got = 0;
    while (!got && k < int'(NP) + 50) begin
      next_cycle();
      clr_start = (k == 20000);
      clr_color = (k == 20000) ? 24'hff0000 : 24'h0000ff;
      settle_check();
      got = m_acc0;
      k++;
    end
    chk("fill_r0_granted", got, 1);
    chk("fill_grant_cycle", k, NP + 1);
    next_cycle(); r0_valid = 0; clr_start = 0; settle_check();

    // Reset in the middle of a fill; r0 is served right after.
    next_cycle();
    r0_valid = 1; r0_adr = 16'd200; r0_d = 24'h777777;
    clr_start = 1; clr_color = 24'h00ff00;
    settle_check();
    repeat (1001) begin next_cycle(); clr_start = 0; settle_check(); end
    apply_reset(1);
    chk("post_rst_r0_acc", m_acc0, 1);
    next_cycle(); r0_valid = 0; settle_check();
    repeat (5) begin next_cycle(); settle_check(); end

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
